// File: rtl/pipe_add.sv
// pipe_add: segmented, pipelined WIDTH-bit adder/subtractor with valid/ready
// handshakes on both sides. Each of the STAGES stages adds one WIDTH/STAGES-bit
// segment and passes its carry to the next stage through a register.
// The last stage register drives the output beat directly.
// Optional build macro: PIPE_ADD_SAT_EN. When it is defined, an overflowing
// result saturates to the signed max/min. When it is not defined, the result
// wraps.
module pipe_add #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ofl,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SEG = WIDTH / STAGES;

    // Stage registers. After stage k loads, sum segments 0..k are final.
    // a/b carry the full operands along (b already inverted for subtract).
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    // Per-stage source operands: the input port for stage 0, else the previous stage.
    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];

    // Handshake: en = stage may load this cycle, go = stage contents move on.
    logic             en [STAGES];
    logic             go [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SEG:0]     seg_sum;
            logic [WIDTH-1:0] s_nxt;

            if (gi == 0) begin : g_src_in
                assign src_v[gi] = in_valid;
                assign src_a[gi] = in_a;
                assign src_b[gi] = in_sub ? ~in_b : in_b;
                assign src_s[gi] = '0;
                assign src_c[gi] = in_cin;
            end else begin : g_src_prev
                assign src_v[gi] = v_q[gi-1];
                assign src_a[gi] = a_q[gi-1];
                assign src_b[gi] = b_q[gi-1];
                assign src_s[gi] = s_q[gi-1];
                assign src_c[gi] = c_q[gi-1];
            end

            // The last stage drains to the consumer. Every other stage drains
            // into its successor. The ready chain lets bubbles collapse.
            if (gi == STAGES - 1) begin : g_go_out
                assign go[gi] = v_q[gi] && out_ready;
            end else begin : g_go_mid
                assign go[gi] = v_q[gi] && en[gi+1];
            end
            assign en[gi] = !v_q[gi] || go[gi];

            // This stage's segment add, with the carry registered by the previous stage.
            assign seg_sum = {1'b0, src_a[gi][gi*SEG +: SEG]}
                           + {1'b0, src_b[gi][gi*SEG +: SEG]}
                           + {{SEG{1'b0}}, src_c[gi]};

            // Insert the new sum segment into the partial sum that rides along.
            always_comb begin
                s_nxt                 = src_s[gi];
                s_nxt[gi*SEG +: SEG]  = seg_sum[SEG-1:0];
            end

            // Stage register: the valid bit follows its source whenever the stage may load.
            // Data is only captured for real beats.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[gi] <= 1'b0;
                    a_q[gi] <= '0;
                    b_q[gi] <= '0;
                    s_q[gi] <= '0;
                    c_q[gi] <= 1'b0;
                end else if (en[gi]) begin
                    v_q[gi] <= src_v[gi];
                    if (src_v[gi]) begin
                        a_q[gi] <= src_a[gi];
                        b_q[gi] <= src_b[gi];
                        s_q[gi] <= s_nxt;
                        c_q[gi] <= seg_sum[SEG];
                    end
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_sum;
    logic             a_msb;
    logic             b_msb;
    logic             raw_ofl;

    assign raw_sum = s_q[STAGES-1];
    assign a_msb   = a_q[STAGES-1][WIDTH-1];
    assign b_msb   = b_q[STAGES-1][WIDTH-1];
    assign raw_ofl = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPE_ADD_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow, clamp toward the sign of A (both operands share that sign).
    always_comb begin
        fin_sum = raw_sum;
        if (raw_ofl) begin
            fin_sum = a_msb ? SMIN : SMAX;
        end
    end
`else
    // Without saturation, the result is the wrapped raw sum.
    always_comb begin
        fin_sum = raw_sum;
    end
`endif

    // Output fields come straight from the last stage register. They hold while
    // it is stalled, and they read as zero while in reset.
    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = fin_sum;
    assign out_cout  = c_q[STAGES-1];
    assign out_ofl   = raw_ofl;
    assign out_zero  = v_q[STAGES-1] && (fin_sum == '0);
    assign out_neg   = fin_sum[WIDTH-1];

endmodule

// File: tb/tb_pipe_add.sv
// Testbench for pipe_add (WIDTH=24, STAGES=3). A queue-based reference model
// computes each result with whole-word arithmetic. One negedge process checks
// every output beat, the hold behaviour while stalled, and the ready/occupancy
// rules. Directed beats also pin the expected values literally.
module tb_pipe_add;

    typedef struct packed {
        logic [23:0] sum;
        logic        cout;
        logic        ofl;
        logic        zero;
        logic        neg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic        out_cout;
    logic        out_ofl;
    logic        out_zero;
    logic        out_neg;

    int total = 0;
    int bad   = 0;

    res_t exp_q[$];
    logic prev_stall = 1'b0;
    res_t prev_fields;

    pipe_add #(.WIDTH(24), .STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ofl(out_ofl),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [23:0] a, input logic [23:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [23:0] bp;
        logic [24:0] full;
        bp     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bp} + {24'd0, cin};
        r.sum  = full[23:0];
        r.cout = full[24];
        r.ofl  = (a[23] == bp[23]) && (r.sum[23] != a[23]);
`ifdef PIPE_ADD_SAT_EN
        if (r.ofl) r.sum = a[23] ? 24'h800000 : 24'h7FFFFF;
`endif
        r.zero = (r.sum == 24'd0);
        r.neg  = r.sum[23];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic res_t cur_out();
        res_t r;
        r.sum  = out_sum;
        r.cout = out_cout;
        r.ofl  = out_ofl;
        r.zero = out_zero;
        r.neg  = out_neg;
        return r;
    endfunction

    // Compare process: outputs are checked on the falling edge. Inputs only
    // change just after a rising edge, so the handshakes seen here are the
    // ones that commit at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_valid", out_valid, 0);
            check("reset_fields", cur_out(), 0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_fields", cur_out(), prev_fields);
            end
            if (!in_ready) check("occupancy_at_stall", exp_q.size(), 3);
            if (out_ready) check("ready_while_draining", in_ready, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", cur_out(), 0);
                end else begin
                    check("result", cur_out(), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
            prev_stall  = out_valid && !out_ready;
            prev_fields = cur_out();
        end
        $display("cyc: in_v=%0d in_r=%0d a=%h b=%h out_v=%0d out_r=%0d sum=%h c=%0d o=%0d z=%0d n=%0d q=%0d",
                 in_valid, in_ready, in_a, in_b, out_valid, out_ready, out_sum,
                 out_cout, out_ofl, out_zero, out_neg, exp_q.size());
    end

    // One beat into an idle pipeline with out_ready held high. Checks the
    // model and the DUT output against a hand-computed value, and checks the latency.
    task automatic single(input string nm, input logic [23:0] a, input logic [23:0] b,
                          input logic cin, input logic sub, input res_t req);
        int lat;
        check({nm, "_model"}, model(a, b, cin, sub), req);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(negedge clk);
        check({nm, "_accept"}, in_ready, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({nm, "_latency"}, lat, 3);
        check({nm, "_literal"}, cur_out(), req);
    endtask

    // Streams n random beats. Mode 0 toggles out_ready 1,0,1,0 and inserts
    // random in_valid gaps. Mode 1 holds in_valid high, keeps out_ready low for
    // 6 cycles to fill the pipe, and then opens it.
    task automatic stream(input string nm, input int n, input int mode);
        logic [23:0] av [16];
        logic [23:0] bv [16];
        logic        cv [16];
        logic        sv [16];
        int   idx;
        int   cyc;
        logic took;
        int   drain;
        for (int i = 0; i < n; i++) begin
            av[i] = 24'($urandom);
            bv[i] = 24'($urandom);
            cv[i] = 1'($urandom_range(0, 1));
            sv[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; cyc = 0; took = 1'b0;
        in_valid = 1'b0;
        while (idx < n && cyc < 400) begin
            @(posedge clk); #1;
            if (took) begin
                idx++;
                in_valid = 1'b0;
            end
            out_ready = (mode == 0) ? (cyc % 2 == 0) : (cyc >= 6);
            if (idx < n) begin
                if (!in_valid)
                    in_valid = (mode == 1) || ($urandom_range(0, 2) != 0);
                in_a = av[idx]; in_b = bv[idx]; in_cin = cv[idx]; in_sub = sv[idx];
            end
            @(negedge clk);
            took = in_valid && in_ready;
            cyc++;
        end
        check({nm, "_all_accepted"}, idx, n);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        check("idle_valid", out_valid, 0);

        single("add_small", 24'h000001, 24'h000002, 1'b0, 1'b0, '{24'h000003, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef PIPE_ADD_SAT_EN
        single("pos_ofl", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, '{24'h7FFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        single("neg_ofl", 24'h800000, 24'h800000, 1'b0, 1'b0, '{24'h800000, 1'b1, 1'b1, 1'b0, 1'b1});
`else
        single("pos_ofl", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, '{24'h800000, 1'b0, 1'b1, 1'b0, 1'b1});
        single("neg_ofl", 24'h800000, 24'h800000, 1'b0, 1'b0, '{24'h000000, 1'b1, 1'b1, 1'b1, 1'b0});
`endif
        single("sub_zero", 24'h000005, 24'h000005, 1'b1, 1'b1, '{24'h000000, 1'b1, 1'b0, 1'b1, 1'b0});
        single("seg_carry", 24'h00FFFF, 24'h000001, 1'b0, 1'b0, '{24'h010000, 1'b0, 1'b0, 1'b0, 1'b0});
        single("cin_wrap", 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, '{24'h000000, 1'b1, 1'b0, 1'b1, 1'b0});
        single("sub_borrow", 24'h000003, 24'h000005, 1'b1, 1'b1, '{24'hFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1});

        stream("toggle", 10, 0);
        stream("fill", 12, 1);

        // Put three beats in flight with the output stalled, then reset mid-flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 24'h111111 * 24'(i + 1); in_b = 24'h000100; in_cin = 1'b0; in_sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_clear_valid", out_valid, 0);
        check("async_clear_sum", out_sum, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        single("post_reset", 24'h123456, 24'h000001, 1'b0, 1'b0, '{24'h123457, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (6) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
